unique0_rr_arbiter: RTL and testbench
=====================================

Name: unique0_rr_arbiter

Overview:
- Round-robin arbiter whose grant vector is zero-or-one-hot by construction. It is the producing side of a unique0 selection: the consumer decodes `gnt` with a unique0 if/case, and zero-or-one conditions are guaranteed true.
- Sits between N requesters and one shared resource.
- Grants are registered and held until the owner signals `done`, drops its request, or a hold timeout expires.

Parameters:
- N, 4: number of requesters (1..32).
- MAX_HOLD, 16: maximum cycles a grant may be held before forced release (>=1).
- IDX_W, N>1 ? $clog2(N) : 1: width of the grant index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, one bit per requester, level-sensitive.
- done  input  1  single-cycle release from the current owner.
- gnt  output  N  registered grant vector, always zero-or-one-hot.
- gnt_idx  output  IDX_W  index of the granted requester; valid only when gnt_valid=1.
- gnt_valid  output  1  high exactly when gnt != 0.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is rst_n, asynchronous assert, active-low.
- Reset values:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - Internal: ptr=0, hold_cnt=0, state=IDLE.
- States are IDLE and GRANT.
- Pick function: first set bit of req, searching circularly from ptr upward (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- IDLE:
  - If req != 0, the next edge loads gnt=onehot(pick), gnt_idx=pick, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency is 1 cycle from req seen high to gnt high.
  - done is ignored in IDLE.
- GRANT: the grant is held unchanged while req[gnt_idx]=1, done=0 and hold_cnt<MAX_HOLD. hold_cnt increments each cycle and saturates at MAX_HOLD.
- Release condition: done=1, OR req[gnt_idx]=0, OR hold_cnt==MAX_HOLD. Any combination in the same cycle counts as a single release.
- On release:
  - ptr <= gnt_idx+1, wrapping to 0 after N-1.
  - If hold_cnt==MAX_HOLD and done=0 and req[gnt_idx]=1, timeout pulses high on the next cycle.
  - The pick for the next grant is evaluated with ptr_next = gnt_idx+1 and with req[gnt_idx] masked out.
  - If another requester is pending: back-to-back grant, no idle bubble. gnt switches directly to the new one-hot value, hold_cnt=1, state stays GRANT.
  - Otherwise gnt=0, gnt_valid=0, state=IDLE.
- Masking rule: the released requester is masked for one pick only. If it is the only requester still high, it is re-granted on the following cycle via IDLE, giving a one-cycle bubble.
- N=1:
  - ptr is always 0.
  - Grant/release alternates with a one-cycle bubble while req stays high.
- Reset mid-grant: all outputs clear immediately (asynchronously); ptr returns to 0.
- Invariants, to be asserted in RTL:
  - $onehot0(gnt) always holds.
  - gnt_valid == |gnt.
  - gnt_valid implies gnt[gnt_idx]=1.
  - timeout implies gnt_valid was 1 in the previous cycle.
- No combinational path from any input to any output.

Decomposition:
- Package unique0_pkg:
  - state_t enum {IDLE, GRANT}.
  - function idx_w(n).
  - function onehot(idx, n).
- Sub-module rr_pick: purely combinational circular priority pick.
  - Inputs: req, ptr, mask.
  - Outputs: found, idx.
  - It contains a unique0 case over the rotated vector, so a multi-hit decode flags an error in simulation.
- The top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan (N=4, MAX_HOLD=8):
- Reset, then req=4'b0000 for 10 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- ptr=0, req=4'b1010 -> next cycle gnt=4'b0010, gnt_idx=1. done pulse -> next cycle gnt=4'b1000, gnt_idx=3, no bubble.
- req=4'b1111 held, done pulsed every 3 cycles -> grants rotate idx 0,1,2,3,0 and $onehot0(gnt) holds every cycle.
- req=4'b0100 held, done never asserted -> gnt=4'b0100 for 8 cycles, then timeout=1 for one cycle, gnt=0 for one cycle (sole requester masked), then re-granted.
- Grant on idx 2, then in the same cycle done=1 and req[2] drops -> exactly one release, ptr=3, no timeout.
- Assert rst_n=0 mid-grant, asynchronously (between clock edges) -> gnt, gnt_valid and gnt_idx are 0 before the next edge. After release, the first grant for req=4'b1000 is idx 3, since ptr=0 searches upward.

Source files
------------

// File: rtl/unique0_rr_arbiter_pkg.sv
// Shared types and helpers for the unique0 round-robin arbiter.
// Grant state encoding plus index-width and one-hot helpers.
package unique0_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] onehot(input int idx, input int n);
        logic [31:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < 32)
            v = 32'd1 << idx;
        return v;
    endfunction

endpackage

// File: rtl/unique0_rr_arbiter_rr_pick.sv
// Combinational circular priority pick starting at ptr.
// The lowest set bit of the rotated vector is isolated, so the decode is unique0.
module rr_pick
    import unique0_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam int SW = IDX_W + 1;
    localparam logic [SW-1:0] NV = SW'(N);

    logic [N-1:0]     w_masked;
    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [N-1:0]     w_lsb;
    logic [31:0]      w_lsb32;
    logic [IDX_W-1:0] w_k;
    logic [SW-1:0]    w_sum;

    assign w_masked = req & ~mask;
    assign w_dbl    = {w_masked, w_masked};
    assign w_rot    = N'(w_dbl >> ptr);
    assign w_lsb    = w_rot & (~w_rot + N'(1));
    assign w_lsb32  = 32'(w_lsb);
    assign found    = |w_rot;

    // Offset of the winning bit relative to ptr.
    always_comb begin
        w_k = '0;
        unique0 case (1'b1)
            w_lsb32[0]:  w_k = IDX_W'(0);
            w_lsb32[1]:  w_k = IDX_W'(1);
            w_lsb32[2]:  w_k = IDX_W'(2);
            w_lsb32[3]:  w_k = IDX_W'(3);
            w_lsb32[4]:  w_k = IDX_W'(4);
            w_lsb32[5]:  w_k = IDX_W'(5);
            w_lsb32[6]:  w_k = IDX_W'(6);
            w_lsb32[7]:  w_k = IDX_W'(7);
            w_lsb32[8]:  w_k = IDX_W'(8);
            w_lsb32[9]:  w_k = IDX_W'(9);
            w_lsb32[10]: w_k = IDX_W'(10);
            w_lsb32[11]: w_k = IDX_W'(11);
            w_lsb32[12]: w_k = IDX_W'(12);
            w_lsb32[13]: w_k = IDX_W'(13);
            w_lsb32[14]: w_k = IDX_W'(14);
            w_lsb32[15]: w_k = IDX_W'(15);
            w_lsb32[16]: w_k = IDX_W'(16);
            w_lsb32[17]: w_k = IDX_W'(17);
            w_lsb32[18]: w_k = IDX_W'(18);
            w_lsb32[19]: w_k = IDX_W'(19);
            w_lsb32[20]: w_k = IDX_W'(20);
            w_lsb32[21]: w_k = IDX_W'(21);
            w_lsb32[22]: w_k = IDX_W'(22);
            w_lsb32[23]: w_k = IDX_W'(23);
            w_lsb32[24]: w_k = IDX_W'(24);
            w_lsb32[25]: w_k = IDX_W'(25);
            w_lsb32[26]: w_k = IDX_W'(26);
            w_lsb32[27]: w_k = IDX_W'(27);
            w_lsb32[28]: w_k = IDX_W'(28);
            w_lsb32[29]: w_k = IDX_W'(29);
            w_lsb32[30]: w_k = IDX_W'(30);
            w_lsb32[31]: w_k = IDX_W'(31);
        endcase
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_k};
    assign idx   = (w_sum >= NV) ? IDX_W'(w_sum - NV) : IDX_W'(w_sum);

endmodule

// File: rtl/unique0_rr_arbiter.sv
// Round-robin arbiter with registered zero-or-one-hot grant.
// Grants hold until done, request drop, or MAX_HOLD timeout.
module unique0_rr_arbiter
    import unique0_pkg::*;
#(
    parameter int  N        = 4,
    parameter int  MAX_HOLD = 16,
    localparam int IDX_W    = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t           r_state, w_state_n;
    logic [N-1:0]     r_gnt, w_gnt_n;
    logic [IDX_W-1:0] r_idx, w_idx_n;
    logic [IDX_W-1:0] r_ptr, w_ptr_n;
    logic [HW-1:0]    r_hold, w_hold_n;
    logic             r_valid, w_valid_n;
    logic             r_timeout, w_timeout_n;

    logic             w_hold_max;
    logic             w_own_req;
    logic             w_release;
    logic [IDX_W-1:0] w_ptr_inc;
    logic [IDX_W-1:0] w_pick_ptr;
    logic [N-1:0]     w_mask;
    logic             w_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic [N-1:0]     w_pick_oh;

    assign w_hold_max = (r_hold == HOLD_MAX);
    assign w_own_req  = req[r_idx];
    assign w_release  = (r_state == GRANT) &&
                        (done || !w_own_req || w_hold_max);
    assign w_ptr_inc  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    // On release the next pick starts after the owner and skips it once.
    assign w_pick_ptr = (r_state == GRANT) ? w_ptr_inc : r_ptr;
    assign w_mask     = (r_state == GRANT) ?
                        N'(onehot(int'(r_idx), N)) : '0;
    assign w_pick_oh  = N'(onehot(int'(w_pick_idx), N));

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .mask  (w_mask),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    // Next-state, grant and hold-counter logic.
    always_comb begin
        w_state_n   = r_state;
        w_gnt_n     = r_gnt;
        w_idx_n     = r_idx;
        w_valid_n   = r_valid;
        w_ptr_n     = r_ptr;
        w_hold_n    = r_hold;
        w_timeout_n = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n = GRANT;
                    w_gnt_n   = w_pick_oh;
                    w_idx_n   = w_pick_idx;
                    w_valid_n = 1'b1;
                    w_hold_n  = HW'(1);
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_n     = w_ptr_inc;
                    w_timeout_n = w_hold_max & ~done & w_own_req;
                    if (w_found) begin
                        w_gnt_n  = w_pick_oh;
                        w_idx_n  = w_pick_idx;
                        w_hold_n = HW'(1);
                    end else begin
                        w_state_n = IDLE;
                        w_gnt_n   = '0;
                        w_idx_n   = '0;
                        w_valid_n = 1'b0;
                        w_hold_n  = '0;
                    end
                end else if (!w_hold_max) begin
                    w_hold_n = r_hold + 1'b1;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_gnt     <= w_gnt_n;
            r_idx     <= w_idx_n;
            r_valid   <= w_valid_n;
            r_ptr     <= w_ptr_n;
            r_hold    <= w_hold_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;

`ifndef SYNTHESIS
    a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_gnt));
    a_valid : assert property (@(posedge clk) disable iff (!rst_n)
        r_valid == |r_gnt);
    a_idx : assert property (@(posedge clk) disable iff (!rst_n)
        r_valid |-> r_gnt[r_idx]);
    a_timeout : assert property (@(posedge clk) disable iff (!rst_n)
        r_timeout |-> $past(r_valid));
`endif

endmodule

// File: tb/tb_unique0_rr_arbiter.sv
// Randomized and directed bench for unique0_rr_arbiter.
// Outputs are compared at negedge against a behavioural arbiter model.
module tb_unique0_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    unique0_rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: current owner (-1 = none), pointer, cycles held, timeout pulse.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    int seen[$];
    int exp_rot[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p,
                                input int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d);
        int p;
        m_to = 0;
        if (m_owner < 0) begin
            p = pick(r, m_ptr, -1);
            if (p >= 0) begin
                m_owner = p;
                m_hold  = 1;
            end
        end else if (d || !r[m_owner] || m_hold == MH) begin
            m_to  = (m_hold == MH) && !d && r[m_owner];
            m_ptr = (m_owner + 1) % N;
            p     = pick(r, m_ptr, m_owner);
            if (p >= 0) begin
                m_owner = p;
                m_hold  = 1;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else if (m_hold < MH) begin
            m_hold++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk({tag, " gnt"}, 32'(gnt), eg);
        chk({tag, " valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        chk({tag, " timeout"}, 32'(timeout), 32'(m_to));
        chk({tag, " onehot0"}, 32'($onehot0(gnt)), 32'd1);
        if (m_owner >= 0)
            chk({tag, " idx"}, 32'(gnt_idx), 32'(m_owner));
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        check_all("model");
    endtask

    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        chk({tag, " gnt"}, 32'(gnt), 32'd0);
        chk({tag, " valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, " idx"}, 32'(gnt_idx), 32'd0);
        chk({tag, " timeout"}, 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset idx", 32'(gnt_idx), 32'd0);
        rst_n = 1'b1;

        // Idle with no requests.
        repeat (10) step(4'b0000, 1'b0);

        // Pick from ptr 0, then back-to-back handover on done.
        step(4'b1010, 1'b0);
        chk("first gnt", 32'(gnt), 32'b0010);
        chk("first idx", 32'(gnt_idx), 32'd1);
        step(4'b1010, 1'b1);
        chk("b2b gnt", 32'(gnt), 32'b1000);
        chk("b2b idx", 32'(gnt_idx), 32'd3);
        step(4'b0000, 1'b0);

        // Full rotation with done every third cycle.
        seen.delete();
        for (int i = 0; i < 12; i++) begin
            step(4'b1111, (i % 3) == 2);
            if (gnt_valid && (seen.size() == 0 || seen[$] != int'(gnt_idx)))
                seen.push_back(int'(gnt_idx));
        end
        chk("rot count", 32'(seen.size()), 32'd5);
        for (int k = 0; k < 5 && k < seen.size(); k++)
            chk("rot order", 32'(seen[k]), 32'(exp_rot[k]));
        step(4'b0000, 1'b0);

        // Sole requester held until forced release.
        for (int i = 0; i < MH; i++) begin
            step(4'b0100, 1'b0);
            chk("hold gnt", 32'(gnt), 32'b0100);
        end
        step(4'b0100, 1'b0);
        chk("to pulse", 32'(timeout), 32'd1);
        chk("to bubble", 32'(gnt), 32'd0);
        step(4'b0100, 1'b0);
        chk("to regrant", 32'(gnt), 32'b0100);
        chk("to clear", 32'(timeout), 32'd0);

        // done and request drop together: one release, ptr moves to 3.
        step(4'b0000, 1'b1);
        chk("dual rel to", 32'(timeout), 32'd0);
        chk("dual rel gnt", 32'(gnt), 32'd0);
        step(4'b1111, 1'b0);
        chk("ptr after dual", 32'(gnt_idx), 32'd3);
        step(4'b0000, 1'b1);

        // Move ptr away from 0, grant, then reset between edges.
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b0);
        chk("pre rst gnt", 32'(gnt), 32'b0100);
        async_reset("async rst");
        step(4'b1000, 1'b0);
        chk("post rst idx", 32'(gnt_idx), 32'd3);
        step(4'b1010, 1'b1);
        chk("post rst ptr", 32'(gnt_idx), 32'd1);
        step(4'b0000, 1'b0);

        // Random traffic with sticky requests and sporadic resets.
        req = 4'($urandom);
        for (int i = 0; i < 800; i++) begin
            logic [3:0] r;
            logic       d;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
            d = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0)
                async_reset("rand rst");
            else
                step(r, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
